// File: rtl/cla_16bit_if.sv
// Operand/result bundle for cla_16bit.
// With CLA_OVF_EN defined it also carries the signed-overflow flag V.
interface cla_16bit_if;
   logic [15:0] A;
   logic [15:0] B;
   logic        C0;
   logic [15:0] S;
   logic        C16;
`ifdef CLA_OVF_EN
   logic        V;

   modport master (output A, B, C0, input S, C16, V);
   modport slave  (input A, B, C0, output S, C16, V);
`else
   modport master (output A, B, C0, input S, C16);
   modport slave  (input A, B, C0, output S, C16);
`endif
endinterface

// File: rtl/cla_16bit.sv
// 16-bit two-level carry-lookahead adder, registered {C16,S} = A + B + C0.
// Define CLA_OVF_EN to add the registered signed-overflow flag V.
module cla_16bit (
   input  logic      clk,
   input  logic      rst,
   cla_16bit_if.slave bus
);

   logic [15:0] g, p;
   logic [3:0]  grp_p, grp_g;
   logic [4:0]  cg;
   logic [15:0] c;
   logic [15:0] s_d, s_q;
   logic        c16_d, c16_q;

   // NOTE: every variable written in an always_comb is assigned on every path, so no latch is inferred.
   always_comb begin
      g = bus.A & bus.B;
      p = bus.A ^ bus.B;
      for (int k = 0; k < 4; k++) begin
         grp_p[k] = &p[4*k +: 4];
         grp_g[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      end
   end

   // Second-level lookahead: every group carry straight from C0 and the group P/G terms.
   always_comb begin
      cg[0] = bus.C0;
      cg[1] = grp_g[0] | (grp_p[0] & bus.C0);
      cg[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & bus.C0);
      cg[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
            | (grp_p[2] & grp_p[1] & grp_p[0] & bus.C0);
      cg[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
            | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
            | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & bus.C0);
   end

   // Carries inside each group, flattened from that group's carry-in.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         c[4*k]   = cg[k];
         c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
      end
      s_d   = p ^ c;
      c16_d = cg[4];
   end

   // NOTE: state uses non-blocking assignments; the reset is synchronous and wins over the inputs on that edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q   <= '0;
         c16_q <= 1'b0;
      end else begin
         s_q   <= s_d;
         c16_q <= c16_d;
      end
   end

   assign bus.S   = s_q;
   assign bus.C16 = c16_q;

`ifdef CLA_OVF_EN
   logic v_d, v_q;

   assign v_d = c[15] ^ cg[4];

   always_ff @(posedge clk) begin
      if (rst) v_q <= 1'b0;
      else     v_q <= v_d;
   end

   assign bus.V = v_q;
`endif

endmodule

// File: tb/tb_cla_16bit.sv
// Self-checking bench for cla_16bit: directed literals plus random stimulus against an A+B+C0 model.
module tb_cla_16bit;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   bit   done;

   cla_16bit_if bus ();

   cla_16bit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: expected outputs after each edge, from the inputs sampled on that edge.
   logic [15:0] exp_s;
   logic        exp_c;
   logic        exp_v;
   bit          exp_valid;

   always @(posedge clk) begin
      logic [16:0] sum;
      sum = {1'b0, bus.A} + {1'b0, bus.B} + {16'b0, bus.C0};
      if (rst) begin
         exp_s <= 16'h0000;
         exp_c <= 1'b0;
         exp_v <= 1'b0;
      end else begin
         exp_s <= sum[15:0];
         exp_c <= sum[16];
         exp_v <= (bus.A[15] == bus.B[15]) && (sum[15] != bus.A[15]);
      end
      exp_valid <= 1'b1;
   end

   always @(negedge clk) begin
      if (exp_valid && !done) begin
         check("model_s", {16'h0, bus.S}, {16'h0, exp_s});
         check("model_c16", {31'h0, bus.C16}, {31'h0, exp_c});
`ifdef CLA_OVF_EN
         check("model_v", {31'h0, bus.V}, {31'h0, exp_v});
`endif
      end
   end

   // Drive one operand set, then return just after the edge that registers it.
   task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic c0);
      bus.A  = a;
      bus.B  = b;
      bus.C0 = c0;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_lit(input string name, input logic [15:0] s, input logic c16, input logic v);
      check({name, "_s"}, {16'h0, bus.S}, {16'h0, s});
      check({name, "_c16"}, {31'h0, bus.C16}, {31'h0, c16});
`ifdef CLA_OVF_EN
      check({name, "_v"}, {31'h0, bus.V}, {31'h0, v});
`else
      if (v) begin end
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rc;
      logic [15:0] ra;
      checks    = 0;
      errors    = 0;
      done      = 1'b0;
      exp_valid = 1'b0;
      rst       = 1'b1;
      bus.A     = 16'hFFFF;
      bus.B     = 16'h0001;
      bus.C0    = 1'b0;

      // Reset holds for two edges despite inputs that would carry out.
      @(posedge clk); #1;
      expect_lit("rst_edge1", 16'h0000, 1'b0, 1'b0);
      apply(16'hFFFF, 16'h0001, 1'b0);
      expect_lit("rst_edge2", 16'h0000, 1'b0, 1'b0);
      rst = 1'b0;

      apply(16'h1234, 16'h4321, 1'b0);  expect_lit("first_load", 16'h5555, 1'b0, 1'b0);
      apply(16'hAAAA, 16'h5555, 1'b1);  expect_lit("alt_cin",    16'h0000, 1'b1, 1'b0);
      apply(16'hFFFF, 16'h0001, 1'b0);  expect_lit("b2b_1",      16'h0000, 1'b1, 1'b0);
      apply(16'h3039, 16'h1538, 1'b0);  expect_lit("b2b_2",      16'h4571, 1'b0, 1'b0);
      apply(16'hFFFF, 16'h0001, 1'b0);  expect_lit("b2b_3",      16'h0000, 1'b1, 1'b0);
      apply(16'hFFFF, 16'h0000, 1'b1);  expect_lit("ffff_cin",   16'h0000, 1'b1, 1'b0);
      apply(16'hFFFF, 16'hFFFF, 1'b1);  expect_lit("max",        16'hFFFF, 1'b1, 1'b0);
      apply(16'h0000, 16'h0000, 1'b0);  expect_lit("zero",       16'h0000, 1'b0, 1'b0);
      apply(16'h7530, 16'h7530, 1'b1);  expect_lit("ovf_pos",    16'hEA61, 1'b0, 1'b1);
      apply(16'h2710, 16'h4E20, 1'b1);  expect_lit("no_ovf",     16'h7531, 1'b0, 1'b0);
      apply(16'h8000, 16'h8000, 1'b0);  expect_lit("ovf_neg",    16'h0000, 1'b1, 1'b1);

      // Carry-chain sweep: carries launched from every bit position, through every length.
      for (int k = 0; k <= 16; k++) begin
         ra = 16'((17'h1 << k) - 17'h1);
         apply(ra, 16'h0001, 1'b0);
         apply(ra, 16'h0000, 1'b1);
         apply(~ra, ra, 1'b1);
         apply(16'h8000 >> (k % 16), 16'hFFFF, 1'b0);
      end

      // Random traffic with one reset pulse dropped in mid-stream.
      rc = $urandom_range(100, 9900);
      for (int i = 0; i < 10000; i++) begin
         if (i == rc) begin
            rst = 1'b1;
            apply(16'($urandom), 16'($urandom), 1'($urandom));
            expect_lit("mid_rst", 16'h0000, 1'b0, 1'b0);
            rst = 1'b0;
         end else begin
            apply(16'($urandom), 16'($urandom), 1'($urandom));
         end
      end

      @(negedge clk);
      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cla_16bit.md
Name: cla_16bit

Overview:
- 16-bit two-level carry-lookahead adder with registered outputs.
- Computes {C16,S} = A + B + C0, one clock of latency.
- Used as the fast adder primitive in datapath/ALU blocks. It is fully pipelined: it accepts a new operand set every cycle and needs no handshake.

Parameters:
- None. Width is fixed at 16 bits; four 4-bit lookahead groups.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- A  input  16  operand A (unsigned; two's complement for the optional overflow flag)
- B  input  16  operand B
- C0  input  1  carry-in
- S  output  16  registered sum bits [15:0]
- C16  output  1  registered carry-out of bit 15

Behaviour:
- Bit level: g[i] = A[i] & B[i]; p[i] = A[i] ^ B[i]; S[i] = p[i] ^ c[i].
- Group level, four 4-bit CLA blocks (bits 3:0, 7:4, 11:8, 15:12):
  - Each block computes its internal carries c[i+1] = g[i] | p[i]&c[i], flattened to sum-of-products, with no ripple inside the block.
  - Each block outputs group propagate P = p3&p2&p1&p0.
  - Each block outputs group generate G = g3 | p3g2 | p3p2g1 | p3p2p1g0.
- Second-level lookahead unit computes C4, C8, C12, C16 directly from C0 and the group P/G, flattened with no inter-group ripple:
  - C4 = G0 | P0C0
  - C8 = G1 | P1G0 | P1P0C0
  - and similarly for C12 and C16.
- Result must equal the arithmetic sum A + B + C0 modulo 2^17 for all 2^33 input combinations.
- Timing:
  - Inputs are sampled on the rising edge of clk.
  - S and C16 update on that same edge and hold until the next edge.
  - Latency is exactly 1 cycle; throughput is 1 result per cycle.
- Reset:
  - On any rising edge with rst=1: S <= 16'h0000, C16 <= 0, plus V <= 0 if present.
  - Reset has priority over the inputs present on that edge.
  - The first edge with rst=0 loads the sum of the inputs present at that edge.
  - Asserting rst mid-stream discards the in-flight result.
- Outputs are undefined before the first clock edge; the bench must apply rst first.
- No X-propagation masking: X on the inputs may propagate to the outputs.
- Boundary cases:
  - FFFF+0000+1 and FFFF+0001+0 give S=0000, C16=1.
  - FFFF+FFFF+1 gives S=FFFF, C16=1.
  - 0000+0000+0 gives S=0000, C16=0.

Optional Feature:
- Macro: CLA_OVF_EN.
- When defined:
  - Adds output port V (output, 1 bit), a registered signed-overflow flag.
  - V = c[15] ^ C16, equivalently (A[15]==B[15]) && (S[15]!=A[15]).
  - V is registered with the same 1-cycle latency as S and resets to 0.
- When undefined: port V does not exist and there is no overflow logic.
- S and C16 behaviour is identical in both builds.

Test Plan:
- rst=1 for 2 edges with A=FFFF, B=0001, C0=0 -> after each edge S=0000, C16=0 (V=0).
- A=1234, B=4321, C0=0 -> next edge S=5555, C16=0.
- Then A=AAAA, B=5555, C0=1 -> next edge S=0000, C16=1.
- Back-to-back, one per cycle:
  - FFFF+0001+0 -> 0000/1
  - 12345+5432+0 -> S=0x4571 (17777), C16=0
  - 65535+1+0 -> 0000/1
  - each result appears exactly one cycle after its inputs.
- 30000+30000+1 -> S=0xEA61 (60001), C16=0, V=1 under CLA_OVF_EN; 10000+20000+1 -> S=0x7531 (30001), C16=0, V=0.
- Randomized plus exhaustive-carry-chain sweep:
  - 10k random A/B/C0 compared against a behavioural A+B+C0 model delayed one cycle.
  - rst asserted on a random cycle mid-stream -> outputs 0 on the next edge, correct results resume on the following cycle.
